alarm_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 36 +++
 rtl/alarm_match.sv | 24 ++
 rtl/alarm_ctrl.sv | 176 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ============================================================================
// Module   : alarm_pkg
// Brief    : Shared state encoding, time-field widths and snooze helper for
//            the alarm sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    // Remaining snoozes, saturated to what the 2-bit status field can show.
    function automatic logic [1:0] snooze_left_f(input int max_snz, input logic [1:0] used);
        int left;
        left = max_snz - int'(used);
        if (left > 3)
            return 2'd3;
        else if (left < 0)
            return 2'd0;
        else
            return 2'(left);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_match.sv
// ============================================================================
// Module   : alarm_match
// Brief    : Combinational alarm-time comparator, qualified by the 1 Hz tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_match
    import alarm_pkg::*;
(
    input  logic            tick,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    input  logic [SS_W-1:0] cur_ss,
    input  logic [HH_W-1:0] alm_hh,
    input  logic [MM_W-1:0] alm_mm,
    output logic            match
);

    assign match = tick & (cur_hh == alm_hh) & (cur_mm == alm_mm) & (cur_ss == '0);

endmodule

`default_nettype wire

// File: rtl/alarm_ctrl.sv
// ============================================================================
// Module   : alarm_ctrl
// Brief    : Alarm sequencer (arm / ring / snooze / timeout) with buzzer drive.
//            Define ALARM_BEEP_EN for a 1 s on / 1 s off buzzer pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic            CLK100MHZ,
    input  logic            reset,
    input  logic            tick,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    input  logic [SS_W-1:0] cur_ss,
    input  logic [HH_W-1:0] alm_hh,
    input  logic [MM_W-1:0] alm_mm,
    input  logic            arm_p,
    input  logic            stop_p,
    input  logic            snooze_p,
    output logic            armed,
    output logic            ringing,
    output logic            snoozing,
    output logic            buzzer,
    output logic [1:0]      snooze_left
);

    localparam int RC_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int SC_W = (SNOOZE_S > 0) ? $clog2(SNOOZE_S + 1) : 1;
    // The 2-bit usage counter caps the number of snoozes at 3.
    localparam int MAX_USED = (MAX_SNOOZE > 3) ? 3 : MAX_SNOOZE;
    localparam logic [1:0] C_MAX_USED  = 2'(MAX_USED);
    localparam logic [1:0] C_LEFT_INIT = 2'(MAX_USED);

    alarm_state_t    state_q, state_d;
    logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SC_W-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]      snz_used_q, snz_used_d;
    logic            armed_q, ringing_q, snoozing_q, buzzer_q;
    logic [1:0]      snooze_left_q, snooze_left_d;
    logic            ringing_d, buzzer_d;
    logic            w_match;

    alarm_match u_match (
        .tick   (tick),
        .cur_hh (cur_hh),
        .cur_mm (cur_mm),
        .cur_ss (cur_ss),
        .alm_hh (alm_hh),
        .alm_mm (alm_mm),
        .match  (w_match)
    );

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        snz_used_d = snz_used_q;

        case (state_q)
            DISARMED: begin
                if (arm_p)
                    state_d = ARMED;
            end
            ARMED: begin
                if (arm_p) begin
                    state_d = DISARMED;
                end else if (w_match) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    snz_used_d = '0;
                end
            end
            RINGING: begin
                if (arm_p) begin
                    state_d = DISARMED;
                end else if (stop_p) begin
                    state_d = ARMED;
                end else if (snooze_p && (snz_used_q < C_MAX_USED)) begin
                    state_d    = SNOOZE;
                    snz_cnt_d  = SC_W'(SNOOZE_S);
                    snz_used_d = snz_used_q + 2'd1;
                end else if (tick) begin
                    if (ring_cnt_q == RC_W'(RING_TIMEOUT_S - 1))
                        state_d = ARMED;
                    else
                        ring_cnt_d = ring_cnt_q + RC_W'(1);
                end
            end
            SNOOZE: begin
                if (arm_p) begin
                    state_d = DISARMED;
                end else if (stop_p) begin
                    state_d = ARMED;
                end else if (tick) begin
                    if (snz_cnt_q == SC_W'(1)) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SC_W'(1);
                    end
                end
            end
            default: state_d = DISARMED;
        endcase

        // Leaving an alarm event restores the full snooze allowance.
        if ((state_d == ARMED) || (state_d == DISARMED))
            snz_used_d = '0;

        snooze_left_d = snooze_left_f(MAX_SNOOZE, snz_used_d);
        ringing_d     = (state_d == RINGING);
    end

`ifdef ALARM_BEEP_EN
    logic beep_q, beep_d;

    always_comb begin
        beep_d = beep_q;
        if ((state_d == RINGING) && (state_q != RINGING))
            beep_d = 1'b0;
        else if ((state_d == RINGING) && tick)
            beep_d = ~beep_q;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset)
            beep_q <= 1'b0;
        else
            beep_q <= beep_d;
    end

    assign buzzer_d = ringing_d & ~beep_d;
`else
    assign buzzer_d = ringing_d;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q       <= DISARMED;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snz_used_q    <= '0;
            armed_q       <= 1'b0;
            ringing_q     <= 1'b0;
            snoozing_q    <= 1'b0;
            buzzer_q      <= 1'b0;
            snooze_left_q <= C_LEFT_INIT;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snz_used_q    <= snz_used_d;
            armed_q       <= (state_d != DISARMED);
            ringing_q     <= ringing_d;
            snoozing_q    <= (state_d == SNOOZE);
            buzzer_q      <= buzzer_d;
            snooze_left_q <= snooze_left_d;
        end
    end

    assign armed       = armed_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign buzzer      = buzzer_q;
    assign snooze_left = snooze_left_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
// ============================================================================
// Module   : tb_alarm_ctrl
// Brief    : Directed self-checking bench for alarm_ctrl (SNOOZE_S=3,
//            RING_TIMEOUT_S=4, MAX_SNOOZE=2). Honours ALARM_BEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] cur_hh = '0;
    logic [5:0] cur_mm = '0;
    logic [5:0] cur_ss = '0;
    logic [4:0] alm_hh = 5'd7;
    logic [5:0] alm_mm = 6'd30;
    logic       arm_p = 1'b0;
    logic       stop_p = 1'b0;
    logic       snooze_p = 1'b0;
    logic       armed, ringing, snoozing, buzzer;
    logic [1:0] snooze_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .SNOOZE_S       (3),
        .RING_TIMEOUT_S (4),
        .MAX_SNOOZE     (2)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .tick        (tick),
        .cur_hh      (cur_hh),
        .cur_mm      (cur_mm),
        .cur_ss      (cur_ss),
        .alm_hh      (alm_hh),
        .alm_mm      (alm_mm),
        .arm_p       (arm_p),
        .stop_p      (stop_p),
        .snooze_p    (snooze_p),
        .armed       (armed),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .buzzer      (buzzer),
        .snooze_left (snooze_left)
    );

    // One clock with the currently driven inputs; pulses cleared afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        tick     = 1'b0;
        arm_p    = 1'b0;
        stop_p   = 1'b0;
        snooze_p = 1'b0;
    endtask

    task automatic do_tick(input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
        cur_hh = hh;
        cur_mm = mm;
        cur_ss = ss;
        tick   = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed); end
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL reset_ringing: got %b want 0", ringing); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %b want 0", snoozing); end
        checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
        checks++; if (snooze_left !== 2'd2) begin errors++; $display("FAIL reset_snooze_left: got %0d want 2", snooze_left); end
    endtask

    task automatic test_match();
        do_tick(5'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL disarmed_match: got %b want 0", ringing); end
        arm_p = 1'b1;
        step();
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL arm: got %b want 1", armed); end
        do_tick(5'd7, 6'd29, 6'd59);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL early_tick: got %b want 0", ringing); end
        do_tick(5'd7, 6'd30, 6'd1);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL late_tick: got %b want 0", ringing); end
        do_tick(5'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL match_ring: got %b want 1", ringing); end
        checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL match_buzzer: got %b want 1", buzzer); end
        checks++; if (snooze_left !== 2'd2) begin errors++; $display("FAIL match_snooze_left: got %0d want 2", snooze_left); end
    endtask

    // Enters with RINGING just started; ringing must survive 3 ticks and drop on the 4th.
    task automatic test_timeout();
        logic exp_buz;
        for (int i = 1; i <= 4; i++) begin
            step();
            step();
            do_tick(5'd7, 6'd30, 6'd0);
`ifdef ALARM_BEEP_EN
            exp_buz = (i < 4) ? ((i % 2) == 0) : 1'b0;
`else
            exp_buz = (i < 4);
`endif
            checks++; if (ringing !== (i < 4)) begin errors++; $display("FAIL timeout_ring_t%0d: got %b want %b", i, ringing, (i < 4)); end
            checks++; if (buzzer !== exp_buz) begin errors++; $display("FAIL timeout_buzzer_t%0d: got %b want %b", i, buzzer, exp_buz); end
        end
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL timeout_armed: got %b want 1", armed); end
    endtask

    task automatic test_snooze();
        do_tick(5'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL snz_start_ring: got %b want 1", ringing); end
        for (int n = 1; n <= 2; n++) begin
            snooze_p = 1'b1;
            step();
            checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snz%0d_snoozing: got %b want 1", n, snoozing); end
            checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL snz%0d_buzzer: got %b want 0", n, buzzer); end
            checks++; if (snooze_left !== 2'(2 - n)) begin errors++; $display("FAIL snz%0d_left: got %0d want %0d", n, snooze_left, 2 - n); end
            for (int t = 1; t <= 3; t++) begin
                do_tick(5'd7, 6'd31, 6'd0);
                checks++; if (ringing !== (t == 3)) begin errors++; $display("FAIL snz%0d_tick%0d_ring: got %b want %b", n, t, ringing, (t == 3)); end
            end
        end
        snooze_p = 1'b1;
        step();
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL snz_exhausted_ring: got %b want 1", ringing); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL snz_exhausted_snoozing: got %b want 0", snoozing); end
        checks++; if (snooze_left !== 2'd0) begin errors++; $display("FAIL snz_exhausted_left: got %0d want 0", snooze_left); end
        stop_p = 1'b1;
        step();
        checks++; if (ringing !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL snz_stop: got ring=%b armed=%b want 0/1", ringing, armed); end
        checks++; if (snooze_left !== 2'd2) begin errors++; $display("FAIL snz_stop_left: got %0d want 2", snooze_left); end
    endtask

    task automatic test_priority();
        do_tick(5'd7, 6'd30, 6'd0);
        snooze_p = 1'b1;
        stop_p   = 1'b1;
        tick     = 1'b1;
        step();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL prio_stop_snooze: got r=%b s=%b a=%b want 0/0/1", ringing, snoozing, armed); end
        do_tick(5'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL prio_rering: got %b want 1", ringing); end
        arm_p  = 1'b1;
        stop_p = 1'b1;
        step();
        checks++; if (armed !== 1'b0 || ringing !== 1'b0) begin errors++; $display("FAIL prio_arm_stop: got a=%b r=%b want 0/0", armed, ringing); end
    endtask

    task automatic test_reset_mid_snooze();
        arm_p = 1'b1;
        step();
        do_tick(5'd7, 6'd30, 6'd0);
        snooze_p = 1'b1;
        step();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL rst_pre_snoozing: got %b want 1", snoozing); end
        reset = 1'b1;
        tick  = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({armed, ringing, snoozing, buzzer} !== 4'b0000) begin errors++; $display("FAIL rst_mid_outputs: got %b want 0000", {armed, ringing, snoozing, buzzer}); end
        checks++; if (snooze_left !== 2'd2) begin errors++; $display("FAIL rst_mid_left: got %0d want 2", snooze_left); end
        do_tick(5'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b0 || armed !== 1'b0) begin errors++; $display("FAIL rst_no_rearm: got r=%b a=%b want 0/0", ringing, armed); end
    endtask

    initial begin
        #2;
        test_reset();
        test_match();
        test_timeout();
        test_snooze();
        test_priority();
        test_reset_mid_snooze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
